// File: rtl/dvi_video_init_seq.sv
// rtl/dvi_video_init_seq.sv - VGA-to-DVI bring-up sequencer (optional TWI retry: DVI_INIT_RETRY_EN)
module dvi_video_init_seq #(
    parameter logic [6:0] DEV_ADDR      = 7'h76,
    parameter int         RST_CYCLES    = 256,
    parameter int         LOCK_TIMEOUT  = 65536,
    parameter int         SETTLE_CYCLES = 1024
) (
    input  logic       iClk,
    input  logic       iRst_neg,
    input  logic       iStart,
    input  logic       iPllLocked,
    output logic       oHardRst,
    output logic       oSoftRst,
    output logic       oTwiReq,
    output logic [6:0] oTwiDev,
    output logic [7:0] oTwiReg,
    output logic [7:0] oTwiData,
    input  logic       iTwiAck,
    input  logic       iTwiErr,
    output logic       oBusy,
    output logic       oRunning,
    output logic       oError,
    output logic [1:0] oErrCode,
    output logic [2:0] oState
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
    localparam logic [RW-1:0] RST_MAX     = RW'(RST_CYCLES);
    localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_TIMEOUT - 1);
    localparam logic [LW-1:0] LOCK_MAX    = LW'(LOCK_TIMEOUT);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);

    localparam logic [2:0] LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HARD_RST  = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_CFG_REQ   = 3'd3,
        S_CFG_WAIT  = 3'd4,
        S_SETTLE    = 3'd5,
        S_RUN       = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    state_t         state;
    state_t         next_state;
    logic           lock_meta;
    logic           lock_s;
    logic [RW-1:0]  rst_cnt;
    logic [LW-1:0]  lock_cnt;
    logic [SW-1:0]  settle_cnt;
    logic [2:0]     idx;
    logic [2:0]     idx_next;
    logic [1:0]     err_code_next;
`ifdef DVI_INIT_RETRY_EN
    logic [1:0]     retry;
    logic [1:0]     retry_next;
`endif

    // Encoder register table: {register address, data}, written in index order
    function automatic logic [15:0] cfg_entry(input logic [2:0] i);
        case (i)
            3'd0:    cfg_entry = {8'h49, 8'hC0};
            3'd1:    cfg_entry = {8'h21, 8'h09};
            3'd2:    cfg_entry = {8'h33, 8'h08};
            3'd3:    cfg_entry = {8'h34, 8'h16};
            3'd4:    cfg_entry = {8'h36, 8'h60};
            default: cfg_entry = 16'h0000;
        endcase
    endfunction

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge iClk or negedge iRst_neg) begin
        if (!iRst_neg) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= iPllLocked;
            lock_s    <= lock_meta;
        end
    end

    // Next-state, table index and error-code decisions
    always_comb begin
        next_state    = state;
        idx_next      = idx;
        err_code_next = oErrCode;
`ifdef DVI_INIT_RETRY_EN
        retry_next    = retry;
`endif
        case (state)
            S_IDLE: begin
                if (iStart) next_state = S_HARD_RST;
            end
            S_HARD_RST: begin
                if (rst_cnt == RST_LAST) next_state = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = S_CFG_REQ;
                    idx_next   = 3'd0;
`ifdef DVI_INIT_RETRY_EN
                    retry_next = 2'd0;
`endif
                end else if (lock_cnt == LOCK_LAST) begin
                    next_state    = S_ERROR;
                    err_code_next = 2'd1;
                end
            end
            S_CFG_REQ: begin
                if (!lock_s) next_state = S_HARD_RST;
                else         next_state = S_CFG_WAIT;
            end
            S_CFG_WAIT: begin
                if (!lock_s) begin
                    next_state = S_HARD_RST;
                end else if (iTwiErr) begin
`ifdef DVI_INIT_RETRY_EN
                    if (retry == 2'd3) begin
                        next_state    = S_ERROR;
                        err_code_next = 2'd2;
                    end else begin
                        next_state = S_CFG_REQ;
                        retry_next = retry + 2'd1;
                    end
`else
                    next_state    = S_ERROR;
                    err_code_next = 2'd2;
`endif
                end else if (iTwiAck) begin
`ifdef DVI_INIT_RETRY_EN
                    retry_next = 2'd0;
`endif
                    if (idx == LAST_IDX) begin
                        next_state = S_SETTLE;
                    end else begin
                        next_state = S_CFG_REQ;
                        idx_next   = idx + 3'd1;
                    end
                end
            end
            S_SETTLE: begin
                if (!lock_s)                         next_state = S_HARD_RST;
                else if (settle_cnt == SETTLE_LAST)  next_state = S_RUN;
            end
            S_RUN: begin
                if (iStart || !lock_s) next_state = S_HARD_RST;
            end
            S_ERROR: begin
                if (iStart) begin
                    next_state    = S_HARD_RST;
                    err_code_next = 2'd0;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State, index and per-state saturating counters (cleared on every state entry)
    always_ff @(posedge iClk or negedge iRst_neg) begin
        if (!iRst_neg) begin
            state      <= S_IDLE;
            idx        <= 3'd0;
            rst_cnt    <= '0;
            lock_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            state <= next_state;
            idx   <= idx_next;
            if (state != S_HARD_RST || next_state != S_HARD_RST) rst_cnt <= '0;
            else if (rst_cnt != RST_MAX)                          rst_cnt <= rst_cnt + 1'b1;
            if (state != S_WAIT_LOCK || next_state != S_WAIT_LOCK) lock_cnt <= '0;
            else if (lock_cnt != LOCK_MAX)                          lock_cnt <= lock_cnt + 1'b1;
            if (state != S_SETTLE || next_state != S_SETTLE) settle_cnt <= '0;
            else if (settle_cnt != SETTLE_MAX)                settle_cnt <= settle_cnt + 1'b1;
        end
    end

`ifdef DVI_INIT_RETRY_EN
    // Consecutive-error count for the entry currently being written
    always_ff @(posedge iClk or negedge iRst_neg) begin
        if (!iRst_neg) retry <= 2'd0;
        else           retry <= retry_next;
    end
`endif

    // Registered outputs decoded from the upcoming state so they line up with oState
    always_ff @(posedge iClk or negedge iRst_neg) begin
        if (!iRst_neg) begin
            oHardRst <= 1'b1;
            oSoftRst <= 1'b1;
            oTwiReq  <= 1'b0;
            oTwiDev  <= DEV_ADDR;
            oTwiReg  <= 8'h00;
            oTwiData <= 8'h00;
            oBusy    <= 1'b0;
            oRunning <= 1'b0;
            oError   <= 1'b0;
            oErrCode <= 2'd0;
        end else begin
            oHardRst <= (next_state == S_HARD_RST);
            oSoftRst <= (next_state != S_RUN);
            oTwiReq  <= (next_state == S_CFG_WAIT);
            oTwiDev  <= DEV_ADDR;
            if (state == S_CFG_REQ) begin
                {oTwiReg, oTwiData} <= cfg_entry(idx);
            end
            oBusy    <= !(next_state == S_IDLE || next_state == S_RUN || next_state == S_ERROR);
            oRunning <= (next_state == S_RUN);
            oError   <= (next_state == S_ERROR);
            oErrCode <= err_code_next;
        end
    end

    assign oState = state;

endmodule

// File: tb/tb_dvi_video_init_seq.sv
// tb/tb_dvi_video_init_seq.sv - directed self-checking bench for dvi_video_init_seq
module tb_dvi_video_init_seq;

    localparam int RC = 8;
    localparam int LT = 64;
    localparam int SC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       locked = 1'b0;
    logic       ack = 1'b0;
    logic       err = 1'b0;
    logic       hard_rst, soft_rst, twi_req, busy, running, error;
    logic [6:0] twi_dev;
    logic [7:0] twi_reg, twi_data;
    logic [1:0] err_code;
    logic [2:0] state;

    int   checks = 0;
    int   errors = 0;
    int   wr_count = 0;
    logic req_prev = 1'b0;

    logic [7:0] treg [5] = '{8'h49, 8'h21, 8'h33, 8'h34, 8'h36};
    logic [7:0] tdat [5] = '{8'hC0, 8'h09, 8'h08, 8'h16, 8'h60};

    dvi_video_init_seq #(
        .DEV_ADDR      (7'h76),
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (LT),
        .SETTLE_CYCLES (SC)
    ) dut (
        .iClk       (clk),
        .iRst_neg   (rst_n),
        .iStart     (start),
        .iPllLocked (locked),
        .oHardRst   (hard_rst),
        .oSoftRst   (soft_rst),
        .oTwiReq    (twi_req),
        .oTwiDev    (twi_dev),
        .oTwiReg    (twi_reg),
        .oTwiData   (twi_data),
        .iTwiAck    (ack),
        .iTwiErr    (err),
        .oBusy      (busy),
        .oRunning   (running),
        .oError     (error),
        .oErrCode   (err_code),
        .oState     (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        req_prev <= twi_req;
        if (twi_req && !req_prev) wr_count <= wr_count + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [10:0] outs();
        return {hard_rst, soft_rst, twi_req, busy, running, error, err_code, state};
    endfunction

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    // mode 0 = ack, 1 = err, 2 = ack and err together
    task automatic serve(input int i, input int mode);
        int n = 0;
        while (twi_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check($sformatf("req_seen%0d", i), 32'(twi_req), 32'd1);
        check($sformatf("wr_addr%0d", i), {17'd0, twi_dev, twi_reg}, {17'd0, 7'h76, treg[i]});
        check($sformatf("wr_data%0d", i), 32'(twi_data), 32'(tdat[i]));
        tick(19);
        check($sformatf("wr_hold%0d", i), {15'd0, twi_req, twi_reg, twi_data},
              {15'd0, 1'b1, treg[i], tdat[i]});
        ack = (mode != 1);
        err = (mode != 0);
        tick();
        ack = 1'b0;
        err = 1'b0;
        check($sformatf("req_drop%0d", i), 32'(twi_req), 32'd0);
    endtask

    task automatic do_cfg();
        int n;
        wait_state("cfg_req_entry", 3'd3, RC + 20);
        for (int i = 0; i < 5; i++) serve(i, 0);
        check("settle_entry", 32'(state), 32'd5);
        n = 1;
        while (soft_rst && n < SC + 20) begin
            tick();
            n++;
        end
        check("settle_len", n, SC + 1);
        check("run_outs", 32'(outs()), 32'({6'b000010, 2'd0, 3'd6}));
    endtask

    initial begin
        int n;
        int w0;

        tick(2);
        check("reset_outs", 32'(outs()), 32'({6'b110000, 2'd0, 3'd0}));
        check("reset_twi", {9'd0, twi_dev, twi_reg, twi_data}, {9'd0, 7'h76, 8'h00, 8'h00});
        rst_n = 1'b1;
        tick(3);
        check("idle_hold", 32'(state), 32'd0);

        // Normal bring-up
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_to_hard", {28'd0, state, hard_rst}, {28'd0, 3'd1, 1'b1});
        n = 0;
        while (state == 3'd1 && n < RC + 20) begin
            n++;
            tick();
        end
        check("hard_len", n, RC);
        check("wait_lock_entry", {28'd0, state, hard_rst}, {28'd0, 3'd2, 1'b0});
        tick(10);
        locked = 1'b1;
        tick(2);
        check("lock_sync_lat", 32'(state), 32'd2);
        tick();
        check("lock_to_cfg", 32'(state), 32'd3);
        do_cfg();
        check("writes_first", wr_count, 5);

        // Lock loss in RUN, then full reprogramming
        locked = 1'b0;
        tick(2);
        check("lossy_run_hold", 32'(state), 32'd6);
        tick();
        check("loss_to_hard", {29'd0, state}, {29'd0, 3'd1});
        check("loss_soft_hard", {30'd0, soft_rst, hard_rst}, {30'd0, 1'b1, 1'b1});
        wait_state("relock_wait", 3'd2, RC + 5);
        locked = 1'b1;
        do_cfg();
        check("writes_second", wr_count, 10);

        // iStart together with lock loss in RUN, then lock timeout
        start = 1'b1;
        locked = 1'b0;
        tick();
        start = 1'b0;
        check("start_loss_hard", 32'(state), 32'd1);
        n = 0;
        while (state == 3'd1 && n < 3 * RC) begin
            n++;
            tick();
        end
        check("single_entry_len", n, RC);
        n = 0;
        while (state == 3'd2 && n < LT + 20) begin
            n++;
            tick();
        end
        check("timeout_len", n, LT);
        check("timeout_outs", 32'(outs()), 32'({6'b010001, 2'd1, 3'd7}));

        // TWI error on entry 2
        locked = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_clear", {27'd0, state, err_code}, {27'd0, 3'd1, 2'd0});
        wait_state("cfg_req_e2", 3'd3, RC + 20);
        w0 = wr_count;
        serve(0, 0);
        serve(1, 0);
`ifdef DVI_INIT_RETRY_EN
        for (int r = 0; r < 4; r++) serve(2, 1);
        check("retry_writes", wr_count - w0, 6);
`else
        serve(2, 1);
        check("err_writes", wr_count - w0, 3);
`endif
        check("twi_err_outs", {26'd0, state, error, err_code}, {26'd0, 3'd7, 1'b1, 2'd2});
        tick(30);
        check("no_more_writes", wr_count - w0, 3 + 3 * ((wr_count - w0) == 6 ? 1 : 0));

`ifndef DVI_INIT_RETRY_EN
        // Simultaneous ack and error on entry 0
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state("cfg_req_both", 3'd3, RC + 20);
        serve(0, 2);
        check("both_outs", {27'd0, state, err_code}, {27'd0, 3'd7, 2'd2});
`endif

        // Async reset while waiting on a TWI write
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_state("cfg_req_rst", 3'd3, RC + 20);
        tick();
        check("req_before_rst", {29'd0, state, twi_req}, {28'd0, 3'd4, 1'b1});
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", 32'(outs()), 32'({6'b110000, 2'd0, 3'd0}));
        check("async_rst_twi", {9'd0, twi_dev, twi_reg, twi_data}, {9'd0, 7'h76, 8'h00, 8'h00});
        tick();
        rst_n = 1'b1;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick(3);
        check("stale_ack", {28'd0, state, twi_req}, {28'd0, 3'd0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
